// File: rtl/nibble_serial_adder_ctrl_if.sv
// nibble_serial_adder_ctrl_if: request/result bundle for the nibble-serial adder; sub exists only with NSA_SUB_EN.
interface nibble_serial_adder_ctrl_if #(parameter int NIBBLES = 4);
  logic                   start;
  logic [4*NIBBLES-1:0]   a;
  logic [4*NIBBLES-1:0]   b;
  logic                   cin;
`ifdef NSA_SUB_EN
  logic                   sub;
`endif
  logic                   busy;
  logic                   done;
  logic [4*NIBBLES-1:0]   sum;
  logic                   cout;
`ifdef NSA_SUB_EN
  modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: adds 4*NIBBLES-bit operands one nibble per cycle through a single fourbitadder.
// Define NSA_SUB_EN to add the sub port (a-b via inverted B and forced carry-in).
module fourbitadder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {4'b0, cin};
endmodule

module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  nibble_serial_adder_ctrl_if.slave    bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d, cout_q, cout_d;
  logic [W-1:0]    b_in;
  logic            c_in, accept, last, add_c;
  logic [3:0]      add_s;
`ifdef NSA_SUB_EN
  assign b_in = bus.sub ? ~bus.b : bus.b;
  assign c_in = bus.sub | bus.cin;
`else
  assign b_in = bus.b;
  assign c_in = bus.cin;
`endif
  fourbitadder u_add (
    .a    (a_q[{idx_q, 2'b00} +: 4]),
    .b    (b_q[{idx_q, 2'b00} +: 4]),
    .cin  (carry_q),
    .s    (add_s),
    .cout (add_c)
  );
  assign accept = (state_q != RUN) && bus.start;
  assign last   = idx_q == IW'(NIBBLES - 1);
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    if (accept) begin
      state_d = RUN;
      a_d     = bus.a;
      b_d     = b_in;
      carry_d = c_in;
      idx_d   = '0;
    end else if (state_q == RUN) begin
      sum_d[{idx_q, 2'b00} +: 4] = add_s;
      carry_d = add_c;
      idx_d   = last ? idx_q : idx_q + IW'(1);
      cout_d  = last ? add_c : cout_q;
      state_d = last ? DONE : RUN;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end
  assign bus.busy = state_q == RUN;
  assign bus.done = state_q == DONE;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl: directed vectors for the nibble-serial adder at NIBBLES=4.
module tb_nibble_serial_adder_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  nibble_serial_adder_ctrl_if #(.NIBBLES(4)) bus ();
  nibble_serial_adder_ctrl #(.NIBBLES(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic st, input logic [15:0] a, input logic [15:0] b, input logic c, input logic sb);
    bus.start = st;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = c;
`ifdef NSA_SUB_EN
    bus.sub   = sb;
`endif
  endtask
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic c,
                        input logic sb, input logic [15:0] es, input logic ec);
    @(negedge clk) drive(1'b1, a, b, c, sb);
    @(negedge clk) drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    chk({tag, "_busy0"}, bus.busy, 1);
    repeat (3) @(negedge clk);
    chk({tag, "_busy3"}, bus.busy, 1);
    chk({tag, "_nodone3"}, bus.done, 0);
    @(negedge clk);
    chk({tag, "_done"}, bus.done, 1);
    chk({tag, "_idle"}, bus.busy, 0);
    chk({tag, "_sum"}, bus.sum, es);
    chk({tag, "_cout"}, bus.cout, ec);
    @(negedge clk);
    chk({tag, "_pulse"}, bus.done, 0);
    chk({tag, "_hold"}, bus.sum, es);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    #12;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_sum", bus.sum, 0);
    chk("rst_cout", bus.cout, 0);
    @(negedge clk) rst_n = 1'b1;
    run_op("t1", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0);
    // abort two edges into a sequence: nibbles 0 and 1 are already rewritten
    @(negedge clk) drive(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b0);
    @(negedge clk) drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 chk("t4_partial", bus.sum, 16'h5500);
    rst_n = 1'b0;
    #1;
    chk("t4_busy", bus.busy, 0);
    chk("t4_done", bus.done, 0);
    chk("t4_sum", bus.sum, 0);
    chk("t4_cout", bus.cout, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t4_nodone", bus.done, 0);
      chk("t4_nobusy", bus.busy, 0);
    end
    run_op("t2", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    run_op("t5", 16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0);
    run_op("tw", 16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0001, 1'b1);
    // start held six edges: only the first and the one in the done cycle are taken
    for (int i = 0; i < 6; i++) begin
      @(negedge clk) drive(1'b1, 16'h1111 * 16'(i + 1), 16'h0101, 1'b0, 1'b0);
      if (i == 5) begin
        chk("t3_done1", bus.done, 1);
        chk("t3_sum1", bus.sum, 16'h1212);
      end
    end
    @(negedge clk) drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("t3_rebusy", bus.busy, 1);
    chk("t3_pulse", bus.done, 0);
    repeat (3) @(negedge clk);
    chk("t3_wait", bus.done, 0);
    @(negedge clk);
    chk("t3_done2", bus.done, 1);
    chk("t3_sum2", bus.sum, 16'h6767);
    chk("t3_cout2", bus.cout, 0);
`ifdef NSA_SUB_EN
    run_op("t6a", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
    run_op("t6b", 16'h0009, 16'h0003, 1'b1, 1'b1, 16'h0006, 1'b1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
